// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared state encoding and default geometry for the instruction loader.
package inst_loader_pkg;
  localparam int DEF_ADDR_W = 6;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    FIN   = 3'd5
  } state_t;
endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if: byte stream in, instruction RAM write port and status out.
interface inst_loader_if #(parameter int ADDR_W = 6);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded
  );
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded
  );
endinterface

// File: rtl/inst_loader_packer.sv
// inst_byte_packer: gathers four bytes little-endian into one 32-bit word.
module inst_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);
  logic [1:0]  r_cnt;
  logic [31:0] r_sr;
  // The word includes the byte arriving this cycle so it can be registered on the 4th edge.
  assign o_word      = {i_byte, r_sr[31:8]};
  assign o_word_full = i_byte_en && (r_cnt == 2'd3);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_byte_en) begin
      r_cnt <= r_cnt + 2'd1;
      r_sr  <= o_word;
    end
  end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: parses length/data/checksum frames and writes instruction words to RAM.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input logic          clk,
  input logic          reset,
  inst_loader_if.slave bus
);
  state_t            r_state;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_cnt;
  logic [7:0]        r_chk;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_ready;
  logic              w_take;
  logic              w_clear;
  logic              w_full;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_nx;
  assign w_ready  = (r_state == LEN) || (r_state == DATA) || (r_state == CHK);
  assign w_take   = bus.rx_valid && w_ready;
  assign w_clear  = (r_state == IDLE) && bus.start;
  assign w_cnt_nx = r_cnt + 1'b1;
  inst_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_byte_en   (w_take && (r_state == DATA)),
    .i_byte      (bus.rx_data),
    .o_word      (w_word),
    .o_word_full (w_full)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_chk   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_chk   <= '0;
          r_busy  <= 1'b1;
          r_state <= LEN;
        end
        LEN: if (w_take) begin
          if (bus.rx_data == 8'd0 || int'(bus.rx_data) > MAX_WORDS) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_n     <= (ADDR_W+1)'(bus.rx_data);
            r_state <= DATA;
          end
        end
        DATA: if (w_take) begin
          r_chk <= r_chk ^ bus.rx_data;
          if (w_full) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= w_word;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_we    <= 1'b0;
          r_cnt   <= w_cnt_nx;
          r_state <= (w_cnt_nx == r_n) ? CHK : DATA;
        end
        CHK: if (w_take) begin
          r_err   <= r_err || (bus.rx_data != r_chk);
          r_done  <= 1'b1;
          r_state <= FIN;
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.rx_ready     = w_ready;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.words_loaded = r_cnt;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: random frame stimulus against a frame-level model, checked by a scoreboard monitor.
module tb_inst_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  inst_loader_if #(.ADDR_W(6)) bus ();
  inst_loader dut (.clk(clk), .reset(reset), .bus(bus));
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int last_take = -10;
  logic [37:0] exp_w[$];
  logic [7:0]  exp_d[$];
  logic [37:0] e_w;
  logic [7:0]  e_d;
  logic [31:0] fw[64];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] xsum(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x ^= fw[i][7:0] ^ fw[i][15:8] ^ fw[i][23:16] ^ fw[i][31:24];
    return x;
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) if (reset) begin
    if (bus.mem_we) begin
      chk("we_latency", 64'(last_take), 64'(cyc - 1));
      chk("ready_in_write", 64'(bus.rx_ready), 64'd0);
      if (exp_w.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_write: got addr %0d data %h, required none", bus.mem_addr, bus.mem_wdata);
      end else begin
        e_w = exp_w.pop_front();
        chk("write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(e_w));
      end
    end
    if (bus.done) begin
      chk("done_latency", 64'(last_take), 64'(cyc - 1));
      if (exp_d.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got err %0b words %0d, required none", bus.err, bus.words_loaded);
      end else begin
        e_d = exp_d.pop_front();
        chk("done_status", 64'({bus.err, bus.words_loaded}), 64'(e_d));
      end
    end
    if (bus.rx_valid && bus.rx_ready) last_take = cyc;
  end
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("byte_timeout", 64'(ok), 64'd1);
    bus.rx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("idle_timeout", 64'(bus.busy), 64'd0);
  endtask
  task automatic send_frame(input logic [7:0] n, input logic [7:0] ck, input int nw, input bit gaps, input bit mid);
    bit legal = (n != 8'd0) && (int'(n) <= 64);
    int wn = (nw < 0) ? int'(n) : nw;
    if (!legal) exp_d.push_back(8'h80);
    else begin
      for (int i = 0; i < wn; i++) exp_w.push_back({6'(i), fw[i]});
      if (nw < 0) exp_d.push_back({ck != xsum(int'(n)), 7'(n)});
    end
    bus.start    = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = n;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("start_clears", 64'({bus.busy, bus.err, bus.words_loaded}), 64'h100);
    send_byte(n, gaps);
    if (legal) begin
      for (int i = 0; i < wn; i++)
        for (int k = 0; k < 4; k++) begin
          send_byte(fw[i][8*k +: 8], gaps);
          if (mid && i == 1 && k == 1) begin
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
          end
        end
      if (nw < 0) send_byte(ck, gaps);
    end
    if (nw < 0 || !legal) wait_idle();
  endtask
  task automatic check_zero(input string nm);
    chk(nm, 64'({bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy, bus.done, bus.err, bus.words_loaded}), 64'd0);
  endtask
  initial begin
    logic [7:0] n;
    logic [7:0] ck;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 64'(bus.busy), 64'd0);
    fw[0] = 32'h12345678;
    fw[1] = 32'hDEADBEEF;
    send_frame(8'd2, 8'h2A, -1, 1'b0, 1'b0);
    chk("nominal_status", 64'({bus.busy, bus.err, bus.words_loaded}), 64'h002);
    send_frame(8'd2, 8'h00, -1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 64'({bus.busy, bus.err, bus.words_loaded}), 64'h082);
    send_frame(8'h00, 8'h00, -1, 1'b0, 1'b0);
    chk("len0_status", 64'({bus.rx_ready, bus.err, bus.words_loaded}), 64'h080);
    send_frame(8'h41, 8'h00, -1, 1'b0, 1'b0);
    chk("len41_status", 64'({bus.rx_ready, bus.err, bus.words_loaded}), 64'h080);
    send_frame(8'd2, 8'h2A, -1, 1'b1, 1'b0);
    chk("gap_status", 64'({bus.err, bus.words_loaded}), 64'h02);
    for (int r = 0; r < 8; r++) begin
      n = 8'($urandom_range(1, 8));
      for (int i = 0; i < int'(n); i++) fw[i] = $urandom;
      ck = xsum(int'(n));
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      send_frame(n, ck, -1, r[0], 1'b0);
      chk("rand_err", 64'({bus.err, bus.words_loaded}), 64'({ck != xsum(int'(n)), 7'(n)}));
    end
    send_frame(8'($urandom_range(65, 255)), 8'h00, -1, 1'b1, 1'b0);
    chk("rand_illegal", 64'(bus.err), 64'd1);
    for (int i = 0; i < 64; i++) fw[i] = 32'(i) * 32'h01010101;
    send_frame(8'd64, xsum(64), -1, 1'b0, 1'b1);
    chk("full_status", 64'({bus.err, bus.words_loaded}), 64'h40);
    send_frame(8'd64, 8'h00, 10, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_zero("midframe_reset");
    chk("abort_writes_seen", 64'(exp_w.size()), 64'd0);
    exp_d.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_busy", 64'({bus.busy, bus.done}), 64'd0);
    fw[0] = 32'h12345678;
    fw[1] = 32'hDEADBEEF;
    send_frame(8'd2, 8'h2A, -1, 1'b1, 1'b0);
    chk("reload_status", 64'({bus.err, bus.words_loaded}), 64'h02);
    repeat (3) @(posedge clk);
    #1;
    chk("writes_drained", 64'(exp_w.size()), 64'd0);
    chk("dones_drained", 64'(exp_d.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream and writes 32-bit instruction words into the instruction RAM write port, starting at word address 0.
- The fetch unit reads the same memory, addressed by PC[7:2].
- busy is high while a load is running; the top level holds the CPU in reset on busy.
- Each frame is: one length byte N, then 4*N data bytes (little-endian per word), then one XOR checksum byte.

Parameters:
- ADDR_W, 6, word-address width; memory depth is 2**ADDR_W words (default 64).
- MAX_WORDS, 2**ADDR_W, largest legal N.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse that begins a load; ignored unless in IDLE.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a frame ends, success or error.
- err  out  1  sticky error flag; cleared by the next accepted start.
- words_loaded  out  ADDR_W+1  number of words written in the current or last frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0: rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded.
  - Byte counter, word index and checksum accumulator are cleared.
  - Reset mid-frame abandons the frame. Words already written stay in the RAM. No done pulse.
- Byte transfer: a byte is taken on a rising edge with rx_valid=1 and rx_ready=1. rx_ready is combinational from state: 1 in LEN, DATA and CHK, 0 elsewhere.
- IDLE:
  - busy=0.
  - On start=1: err<=0, words_loaded<=0, checksum<=0, word index<=0, go to LEN. busy=1 from the next cycle.
- LEN:
  - Accept one byte N.
  - If N==0 or N>MAX_WORDS: err<=1, go to FIN.
  - Otherwise latch N and go to DATA.
- DATA:
  - Accept bytes into the packer. Byte k (k=0..3) goes to wdata[8k+7:8k].
  - Every accepted byte is XORed into the checksum.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word index, mem_wdata=assembled word. All three are registered and stable for the whole cycle.
  - Next edge: word index+1, words_loaded+1.
  - If the new index==N, go to CHK; otherwise go to DATA.
  - mem_we is 1 only in WRITE. Latency from the 4th byte's edge to mem_we=1 is one cycle.
- CHK:
  - Accept one byte.
  - If it differs from the accumulated checksum, err<=1.
  - Go to FIN.
- FIN (one cycle):
  - done=1, busy=1.
  - Next state IDLE; busy drops on the following edge.
- Boundary rules:
  - N==MAX_WORDS: the index reaches 64 in the ADDR_W+1-bit counter; mem_addr uses the low ADDR_W bits, so the last write is to address 63. No wrap write occurs.
  - start while busy: no effect.
  - rx_valid while rx_ready=0: byte not consumed; the source must hold it.
  - Idle gaps (rx_valid=0) in any accepting state leave state unchanged. There is no timeout.
  - rx_valid and start in the same IDLE cycle: the byte is not taken, because rx_ready=0 in IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE, LEN, DATA, WRITE, CHK, FIN, 3 bits) and the default depth constant.
- One sub-module, inst_byte_packer:
  - 2-bit byte counter plus a 32-bit little-endian shift register.
  - Inputs: clk, reset, clear, byte_en, byte.
  - Outputs: word, word_full (pulse on the 4th byte).
- The FSM, counters and checksum stay in inst_loader.

Test Plan:
- Reset: drive reset=0 mid-simulation -> all outputs 0 immediately (asynchronous), state IDLE; on release, busy stays 0 until start.
- Nominal load: start, then N=0x02, then bytes 78 56 34 12 EF BE AD DE, then checksum 0x2A -> mem_we pulses with addr0=0x12345678 and addr1=0xDEADBEEF, each one cycle after its 4th byte; then done pulse, err=0, words_loaded=2, busy falls.
- Bad checksum: same frame with checksum 0x00 -> both words still written, done pulse, err=1 held until the next start.
- Illegal length: N=0x00, and separately N=0x41 -> no mem_we, err=1, done pulse one cycle after the length byte, rx_ready=0 afterwards.
- Backpressure and gaps: random rx_valid gaps, and rx_valid held high through WRITE -> rx_ready=0 in WRITE, no byte lost or duplicated, written data matches the nominal case.
- Full depth and abuse:
  - N=64 with word i = i*0x01010101 -> addresses 0..63 written, last write at 63, words_loaded=64.
  - start pulse mid-frame -> ignored.
  - reset=0 after word 10 -> busy=0, no done pulse; a new start then loads normally.
